// File: rtl/rs232_rx_buffer_if.sv
// Bus bundle for rs232_rx_buffer: serial line in, buffer read port, status out.
// master = the side that drives the line and picks the read entry; slave = the receiver.
interface rs232_rx_buffer_if;
    logic       iRX;
    logic [2:0] read_addr;
    logic [7:0] oData;
    logic [2:0] oRx_addr;
    logic       oRxValid;
    logic       oFrameErr;
    logic       oParityErr;

    modport master (
        output iRX, read_addr,
        input  oData, oRx_addr, oRxValid, oFrameErr, oParityErr
    );

    modport slave (
        input  iRX, read_addr,
        output oData, oRx_addr, oRxValid, oFrameErr, oParityErr
    );
endinterface

// File: rtl/rs232_rx_buffer.sv
// RS232 receiver feeding an 8-entry circular byte buffer with a registered read port.
// Frames are 8N1 by default; defining RS232_RX_PARITY_EN switches to 8E1 and
// enables the sticky parity error flag.
module rs232_rx_buffer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               iClk,
    input  logic               iRst,
    rs232_rx_buffer_if.slave   bus
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef RS232_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t      state;
    logic        rxMeta;
    logic        rxSync;
    logic [15:0] bitCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic [7:0]  mem [0:7];
    logic        commit;

`ifdef RS232_RX_PARITY_EN
    logic        parBad;
    // Byte is committed only on a good stop bit of a frame with correct parity
    assign commit = (state == STOP) && (bitCnt == 16'd0) && rxSync && !parBad;
`else
    assign commit = (state == STOP) && (bitCnt == 16'd0) && rxSync;
    assign bus.oParityErr = 1'b0;
`endif

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= bus.iRX;
            rxSync <= rxMeta;
        end
    end

    // Receive FSM: mid-bit sampling from a half-bit offset after the start edge
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= IDLE;
            bitCnt        <= 16'd0;
            bitIdx        <= 3'd0;
            shiftReg      <= 8'd0;
            bus.oRx_addr  <= 3'd0;
            bus.oRxValid  <= 1'b0;
            bus.oFrameErr <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parBad         <= 1'b0;
            bus.oParityErr <= 1'b0;
`endif
        end else begin
            bus.oRxValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxSync) begin
                        bitCnt <= HALF_BIT;
                        state  <= START;
                    end
                end
                START: begin
                    if (bitCnt != 16'd0) begin
                        bitCnt <= bitCnt - 16'd1;
                    end else if (!rxSync) begin
                        bitCnt <= FULL_BIT;
                        bitIdx <= 3'd0;
`ifdef RS232_RX_PARITY_EN
                        parBad <= 1'b0;
`endif
                        state  <= DATA;
                    end else begin
                        // Line went back high before mid-start: glitch, not a frame
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (bitCnt != 16'd0) begin
                        bitCnt <= bitCnt - 16'd1;
                    end else begin
                        bitCnt   <= FULL_BIT;
                        shiftReg <= {rxSync, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef RS232_RX_PARITY_EN
                PARITY: begin
                    if (bitCnt != 16'd0) begin
                        bitCnt <= bitCnt - 16'd1;
                    end else begin
                        bitCnt <= FULL_BIT;
                        // Even parity: parity bit must equal XOR of the data bits
                        if (rxSync != ^shiftReg) begin
                            parBad         <= 1'b1;
                            bus.oParityErr <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bitCnt != 16'd0) begin
                        bitCnt <= bitCnt - 16'd1;
                    end else if (rxSync) begin
                        if (commit) begin
                            bus.oRx_addr <= bus.oRx_addr + 3'd1;
                            bus.oRxValid <= 1'b1;
                        end
                        // Back to IDLE at mid-stop so a back-to-back start is caught
                        state <= IDLE;
                    end else begin
                        bus.oFrameErr <= 1'b1;
                        state         <= BREAK;
                    end
                end
                BREAK: begin
                    if (rxSync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer write; no reset so contents survive it, and an aborted frame never writes
    always_ff @(posedge iClk) begin
        if (!iRst && commit) mem[bus.oRx_addr] <= shiftReg;
    end

    // Registered read port; a same-cycle write to the read entry shows up one cycle later
    always_ff @(posedge iClk) begin
        if (iRst) bus.oData <= 8'd0;
        else      bus.oData <= mem[bus.read_addr];
    end

endmodule

// File: tb/tb_rs232_rx_buffer.sv
// Self-checking bench for rs232_rx_buffer at CLKS_PER_BIT=16: vector table of
// frames plus hand sequences for glitch, mid-frame reset, wrap and read/write collision.
module tb_rs232_rx_buffer;

    localparam int CPB = 16;

    logic iClk = 1'b0;
    logic iRst;
    rs232_rx_buffer_if bus();

    rs232_rx_buffer #(.CLKS_PER_BIT(CPB)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         stopLen;
        logic       parFlip;
        logic       expWrite;
        logic       expFrame;
        logic       expPar;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] expQ[$];
    logic [7:0] mdl [0:7];
    logic [2:0] maddr;
    logic       mframe;
    logic       mpar;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b, input int n);
        bus.iRX = b;
        repeat (n) @(negedge iClk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int stopLen,
                             input logic parFlip);
        sendBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) sendBit(d[i], CPB);
`ifdef RS232_RX_PARITY_EN
        sendBit((^d) ^ parFlip, CPB);
`endif
        sendBit(stopBit, stopLen);
        bus.iRX = 1'b1;
    endtask

    task automatic doReset(input int n);
        iRst = 1'b1;
        repeat (n) @(negedge iClk);
        chk("reset_addr", 32'(bus.oRx_addr), 32'd0);
        chk("reset_valid", 32'(bus.oRxValid), 32'd0);
        chk("reset_frame", 32'(bus.oFrameErr), 32'd0);
        chk("reset_parity", 32'(bus.oParityErr), 32'd0);
        chk("reset_data", 32'(bus.oData), 32'd0);
        iRst = 1'b0;
        maddr = 3'd0;
        mframe = 1'b0;
        mpar = 1'b0;
    endtask

    // Scoreboard: every commit pulse must match a pending expected write
    always @(negedge iClk) begin
        if (!iRst && bus.oRxValid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit: got addr %0d expected no write", bus.oRx_addr);
            end else begin
                logic [2:0] e;
                e = expQ.pop_front();
                chk("commit_addr", 32'(bus.oRx_addr), 32'(e));
            end
        end
    end

    initial begin
        bus.iRX = 1'b1;
        bus.read_addr = 3'd0;
        iRst = 1'b1;

        vecs.push_back('{8'hA5, 1'b1, CPB, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 40,  1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h55, 1'b1, CPB, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hC3, 1'b1, CPB, 1'b0, 1'b1, 1'b0, 1'b0});
`ifdef RS232_RX_PARITY_EN
        vecs.push_back('{8'h01, 1'b1, CPB, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h03, 1'b1, CPB, 1'b0, 1'b1, 1'b0, 1'b0});
`endif

        doReset(3);
        sendBit(1'b1, 10);

        // Table-driven frames
        foreach (vecs[k]) begin
            if (vecs[k].expWrite) begin
                mdl[maddr] = vecs[k].data;
                expQ.push_back(maddr + 3'd1);
                maddr = maddr + 3'd1;
            end
            if (vecs[k].expFrame) mframe = 1'b1;
            if (vecs[k].expPar)   mpar = 1'b1;
            sendFrame(vecs[k].data, vecs[k].stopBit, vecs[k].stopLen, vecs[k].parFlip);
            sendBit(1'b1, 20);
            chk("vec_addr", 32'(bus.oRx_addr), 32'(maddr));
            chk("vec_frame", 32'(bus.oFrameErr), 32'(mframe));
            chk("vec_parity", 32'(bus.oParityErr), 32'(mpar));
            if (vecs[k].expWrite) begin
                bus.read_addr = maddr - 3'd1;
                @(negedge iClk);
                chk("vec_readback", 32'(bus.oData), 32'(vecs[k].data));
            end
        end

        // Short low glitch: false start, nothing written
        sendBit(1'b0, 4);
        sendBit(1'b1, 40);
        chk("glitch_addr", 32'(bus.oRx_addr), 32'(maddr));
        chk("glitch_frame", 32'(bus.oFrameErr), 32'(mframe));

        // Reset during bit 4 of 0xFF aborts the frame and clears flags
        sendBit(1'b0, CPB);
        sendBit(1'b1, 4 * CPB + 5);
        doReset(3);
        sendBit(1'b1, 8 * CPB);
        chk("midreset_addr", 32'(bus.oRx_addr), 32'd0);
        chk("midreset_frame", 32'(bus.oFrameErr), 32'd0);
        mdl[0] = 8'h12;
        expQ.push_back(3'd1);
        maddr = 3'd1;
        sendFrame(8'h12, 1'b1, CPB, 1'b0);
        sendBit(1'b1, 20);
        chk("after_reset_addr", 32'(bus.oRx_addr), 32'd1);
        bus.read_addr = 3'd0;
        @(negedge iClk);
        chk("after_reset_data", 32'(bus.oData), 32'h12);
        bus.read_addr = 3'd1;
        @(negedge iClk);
        chk("buffer_survives_reset", 32'(bus.oData), 32'h55);

        // Wrap: 9 bytes from entry 0, 9th overwrites entry 0
        doReset(2);
        sendBit(1'b1, 5);
        for (int k = 0; k < 8; k++) begin
            mdl[maddr] = 8'(k);
            expQ.push_back(maddr + 3'd1);
            maddr = maddr + 3'd1;
            sendFrame(8'(k), 1'b1, CPB, 1'b0);
            sendBit(1'b1, 4);
        end
        chk("wrap_addr_full", 32'(bus.oRx_addr), 32'd0);
        bus.read_addr = 3'd0;
        sendBit(1'b1, 4);
        chk("collide_pre", 32'(bus.oData), 32'h00);
        mdl[0] = 8'h08;
        expQ.push_back(3'd1);
        maddr = 3'd1;
        fork
            sendFrame(8'h08, 1'b1, CPB, 1'b0);
            begin
                int t;
                t = 0;
                while (!bus.oRxValid && t < 400) begin
                    @(negedge iClk);
                    t++;
                end
                if (!bus.oRxValid) begin
                    chk("collide_timeout", 32'd0, 32'd1);
                end else begin
                    chk("collide_old", 32'(bus.oData), 32'h00);
                    @(negedge iClk);
                    chk("collide_new", 32'(bus.oData), 32'h08);
                end
            end
        join
        sendBit(1'b1, 10);
        chk("wrap_addr", 32'(bus.oRx_addr), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus.read_addr = 3'(i);
            @(negedge iClk);
            chk("wrap_readback", 32'(bus.oData), 32'(mdl[i]));
        end

        chk("pending_commits", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
